// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter that shares one NUM_REQ:1 mux tree between NUM_REQ
// requesters. The one-hot grant and the matching binary select are both
// registered, so the mux select stays glitch-free and stable for a whole
// tenure. Each tenure is limited to MAX_HOLD cycles. When that limit is
// reached and another requester is waiting, the grant is force-rotated.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   req       request vector; a requester holds its bit high while it wants the mux
//   grant     registered one-hot grant; all zeros when idle
//   sel       registered binary index of the owner; drives the mux tree sel
//   gnt_valid high while any grant is active
//   preempt   one-cycle pulse, aligned with a grant change caused by a timeout
//   hold_cnt  cycles elapsed in the current tenure
//
// Optional feature, enabled by defining the macro MUX_ARB_PRIO_EN:
//   Requester 0 becomes high priority. It wins every arbitration it takes
//   part in and is never preempted; its hold_cnt saturates at MAX_HOLD-1.
//   Requesters 1..NUM_REQ-1 stay round-robin among themselves.
module mux_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SEL_WIDTH = 2,
    parameter int MAX_HOLD  = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 gnt_valid,
    output logic                 preempt,
    output logic [CNT_WIDTH-1:0] hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1'b1);
    localparam logic [SEL_WIDTH-1:0] SEL_ONE   = SEL_WIDTH'(1'b1);
    localparam logic [SEL_WIDTH-1:0] SEL_ZERO  = {SEL_WIDTH{1'b0}};
    localparam logic [NUM_REQ-1:0]   GNT_ONE   = NUM_REQ'(1'b1);
    localparam logic [NUM_REQ-1:0]   GNT_ZERO  = {NUM_REQ{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};

    state_t               state_r, state_nxt_s;
    logic [SEL_WIDTH-1:0] ptr_r, ptr_nxt_s;
    logic [NUM_REQ-1:0]   grant_nxt_s;
    logic [SEL_WIDTH-1:0] sel_nxt_s;
    logic                 valid_nxt_s;
    logic                 preempt_nxt_s;
    logic [CNT_WIDTH-1:0] hold_nxt_s;
    logic [SEL_WIDTH:0]   idle_pick_s;   // {found, index}
    logic [SEL_WIDTH:0]   busy_pick_s;   // {found, index}, owner excluded
    logic [SEL_WIDTH-1:0] after_owner_s;
    logic                 owner_req_s;
    logic                 owner_prio_s;

    // Searches from start upward, wrapping modulo NUM_REQ, and returns the
    // first set requester, optionally skipping the index excl. NUM_REQ is a
    // power of two, so the wrap comes from the natural SEL_WIDTH overflow.
    function automatic logic [SEL_WIDTH:0] rr_pick(
        input logic [NUM_REQ-1:0]   r,
        input logic [SEL_WIDTH-1:0] start,
        input logic                 excl_en,
        input logic [SEL_WIDTH-1:0] excl
    );
        logic                 found;
        logic [SEL_WIDTH-1:0] idx;
        logic [SEL_WIDTH-1:0] cand;
        found = 1'b0;
        idx   = SEL_ZERO;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = start + SEL_WIDTH'(k);
            if (!found && r[cand] && !(excl_en && (cand == excl))) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Full arbitration. With the priority feature, requester 0 is checked
    // first, and the round-robin search then only considers 1..NUM_REQ-1.
    function automatic logic [SEL_WIDTH:0] arb_pick(
        input logic [NUM_REQ-1:0]   r,
        input logic [SEL_WIDTH-1:0] start,
        input logic                 excl_en,
        input logic [SEL_WIDTH-1:0] excl
    );
`ifdef MUX_ARB_PRIO_EN
        logic [NUM_REQ-1:0] r_low;
        r_low    = r;
        r_low[0] = 1'b0;
        if (r[0] && !(excl_en && (excl == SEL_ZERO))) begin
            return {1'b1, SEL_ZERO};
        end else begin
            return rr_pick(r_low, start, excl_en, excl);
        end
`else
        return rr_pick(r, start, excl_en, excl);
`endif
    endfunction

    assign after_owner_s = sel + SEL_ONE;
    assign owner_req_s   = req[sel];
    assign idle_pick_s   = arb_pick(req, ptr_r, 1'b0, SEL_ZERO);
    // The owner is re-arbitrated from the slot just after itself on both
    // release and timeout, which makes the rotation order predictable.
    assign busy_pick_s   = arb_pick(req, after_owner_s, 1'b1, sel);
`ifdef MUX_ARB_PRIO_EN
    assign owner_prio_s  = (sel == SEL_ZERO);
`else
    assign owner_prio_s  = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        grant_nxt_s   = grant;
        sel_nxt_s     = sel;
        valid_nxt_s   = gnt_valid;
        preempt_nxt_s = 1'b0;
        hold_nxt_s    = hold_cnt;
        case (state_r)
            IDLE: begin
                if (idle_pick_s[SEL_WIDTH]) begin
                    state_nxt_s = GRANT;
                    grant_nxt_s = GNT_ONE << idle_pick_s[SEL_WIDTH-1:0];
                    sel_nxt_s   = idle_pick_s[SEL_WIDTH-1:0];
                    valid_nxt_s = 1'b1;
                    hold_nxt_s  = CNT_ZERO;
                end else begin
                    grant_nxt_s = GNT_ZERO;
                    valid_nxt_s = 1'b0;
                    hold_nxt_s  = CNT_ZERO;
                end
            end
            GRANT: begin
                if (!owner_req_s) begin
                    // Release: hand over in the same cycle with no bubble.
                    // If nobody else is waiting, go idle and leave sel as it is.
                    ptr_nxt_s  = after_owner_s;
                    hold_nxt_s = CNT_ZERO;
                    if (busy_pick_s[SEL_WIDTH]) begin
                        grant_nxt_s = GNT_ONE << busy_pick_s[SEL_WIDTH-1:0];
                        sel_nxt_s   = busy_pick_s[SEL_WIDTH-1:0];
                    end else begin
                        state_nxt_s = IDLE;
                        grant_nxt_s = GNT_ZERO;
                        valid_nxt_s = 1'b0;
                    end
                end else if (owner_prio_s) begin
                    // The high-priority owner is never timed out; its counter saturates.
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt_s = HOLD_LAST;
                    end else begin
                        hold_nxt_s = hold_cnt + CNT_ONE;
                    end
                end else if (hold_cnt == HOLD_LAST) begin
                    // Timeout: rotate only if someone else is waiting; otherwise
                    // the sole requester keeps the grant and its counter wraps.
                    hold_nxt_s = CNT_ZERO;
                    if (busy_pick_s[SEL_WIDTH]) begin
                        grant_nxt_s   = GNT_ONE << busy_pick_s[SEL_WIDTH-1:0];
                        sel_nxt_s     = busy_pick_s[SEL_WIDTH-1:0];
                        ptr_nxt_s     = after_owner_s;
                        preempt_nxt_s = 1'b1;
                    end else begin
                        preempt_nxt_s = 1'b0;
                    end
                end else begin
                    hold_nxt_s = hold_cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = GNT_ZERO;
                valid_nxt_s = 1'b0;
                hold_nxt_s  = CNT_ZERO;
            end
        endcase
    end

    // State, pointer and output registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= SEL_ZERO;
            grant     <= GNT_ZERO;
            sel       <= SEL_ZERO;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            hold_cnt  <= CNT_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            grant     <= grant_nxt_s;
            sel       <= sel_nxt_s;
            gnt_valid <= valid_nxt_s;
            preempt   <= preempt_nxt_s;
            hold_cnt  <= hold_nxt_s;
        end
    end

endmodule
